// File: rtl/instr_mem_stream_if.sv
// instr_mem_stream_if
//   Request/response bundle between the fetch stage and instr_mem_stream.
//   master : fetch stage (drives requests, flush, rsp_ready)
//   slave  : instruction memory (drives req_ready and the response fields)
// Signals
//   req_valid/req_ready/req_addr        request channel (word address)
//   flush                               drop all in-flight and buffered fetches
//   rsp_valid/rsp_ready                 response channel handshake
//   rsp_instr/rsp_addr/rsp_err          instruction, its address, out-of-range flag
interface instr_mem_stream_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  flush;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_instr;
  logic [ADDR_WIDTH-1:0] rsp_addr;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, flush, rsp_ready,
    input  req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, flush, rsp_ready,
    output req_ready, rsp_valid, rsp_instr, rsp_addr, rsp_err
  );
endinterface

// File: rtl/instr_mem_stream.sv
// instr_mem_stream
//   Streaming instruction ROM. Requests enter over a valid/ready channel, read
//   a synchronous block RAM through a 1- or 2-stage pipeline, and land in a
//   small response FIFO that absorbs fetch-stage backpressure. Requests are
//   credit-limited so every in-flight read always has a FIFO slot.
// Ports
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    instr_mem_stream_if.slave (request, flush, response channels)
// Optional feature
//   IMEM_BOUNDS_CHECK_EN : addresses >= DEPTH return FILL_WORD with rsp_err=1
//   and never index the ROM. Without it the ROM is indexed by the low
//   clog2(DEPTH) address bits (DEPTH a power of 2) and rsp_err stays 0.
module instr_mem_stream #(
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DATA_WIDTH   = 16,
  parameter int                    DEPTH        = 1 << ADDR_WIDTH,
  parameter int                    READ_LATENCY = 1,
  parameter int                    RSP_DEPTH    = 4,
  parameter string                 INIT_FILE    = "mem/program.hex",
  parameter logic [DATA_WIDTH-1:0] FILL_WORD    = '0
) (
  input logic               clk,
  input logic               rst_n,
  instr_mem_stream_if.slave bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  logic                  ready_en;
  logic                  accept;
  logic                  req_err;
  logic                  rom_en;
  logic [IDX_W-1:0]      rom_idx;
  logic [DATA_WIDTH-1:0] ram_q;

  logic                  v1;
  logic [ADDR_WIDTH-1:0] a1;
  logic                  e1;
  logic [DATA_WIDTH-1:0] d1;

  logic                  out_v;
  logic [ADDR_WIDTH-1:0] out_addr;
  logic                  out_err;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            inflight;

  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr [RSP_DEPTH];
  logic                  fifo_err  [RSP_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic [SUM_W-1:0]      occupancy;
  logic                  push;
  logic                  pop;

  // Keeps the init-file parameter referenced in builds without file init.
  logic unused_init;
  assign unused_init = (INIT_FILE == "");

  // req_ready stays low until the first clock after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign occupancy     = SUM_W'(inflight) + SUM_W'(count);
  assign bus.req_ready = ready_en && !bus.flush && (occupancy < SUM_W'(RSP_DEPTH));
  assign accept        = bus.req_valid && bus.req_ready;

`ifdef IMEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
  assign req_err = ({1'b0, bus.req_addr} >= DEPTH_W);
  assign rom_en  = accept && !req_err;
`else
  assign req_err = 1'b0;
  assign rom_en  = accept;
`endif

  assign rom_idx = (DEPTH == 1) ? '0 : bus.req_addr[IDX_W-1:0];

  (* ram_init_file = INIT_FILE *) logic [DATA_WIDTH-1:0] rom [DEPTH];

  always_ff @(posedge clk) begin
    if (rom_en) ram_q <= rom[rom_idx];
  end

  // Stage 1 tracks the RAM read; address and error ride alongside the data.
  // Flush needs no explicit term: req_ready is low, so accept is 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      e1 <= 1'b0;
    end else begin
      v1 <= accept;
      if (accept) begin
        a1 <= bus.req_addr;
        e1 <= req_err;
      end
    end
  end

  assign d1 = e1 ? FILL_WORD : ram_q;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  v2;
      logic [ADDR_WIDTH-1:0] a2;
      logic                  e2;
      logic [DATA_WIDTH-1:0] d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2 <= 1'b0;
          a2 <= '0;
          e2 <= 1'b0;
          d2 <= '0;
        end else if (bus.flush) begin
          v2 <= 1'b0;
        end else begin
          v2 <= v1;
          if (v1) begin
            a2 <= a1;
            e2 <= e1;
            d2 <= d1;
          end
        end
      end

      assign out_v    = v2;
      assign out_addr = a2;
      assign out_err  = e2;
      assign out_data = d2;
      assign inflight = {1'b0, v1} + {1'b0, v2};
    end else begin : g_lat1
      assign out_v    = v1;
      assign out_addr = a1;
      assign out_err  = e1;
      assign out_data = d1;
      assign inflight = {1'b0, v1};
    end
  endgenerate

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Credits guarantee a free slot for every push, so push never sees a full FIFO.
  assign push = out_v && !bus.flush;
  assign pop  = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
        fifo_err[i]  <= 1'b0;
      end
    end else if (bus.flush) begin
      // A pop in this cycle has already been seen by the consumer; emptying
      // the FIFO covers it as well.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= out_data;
        fifo_addr[wr_ptr] <= out_addr;
        fifo_err[wr_ptr]  <= out_err;
        wr_ptr            <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.rsp_valid = (count != '0);
  assign bus.rsp_instr = fifo_data[rd_ptr];
  assign bus.rsp_addr  = fifo_addr[rd_ptr];
  assign bus.rsp_err   = fifo_err[rd_ptr];

endmodule

// File: tb/tb_instr_mem_stream.sv
// tb_instr_mem_stream
//   Two instances (READ_LATENCY 1 and 2, DEPTH 256, RSP_DEPTH 4) share one
//   stimulus. ROM is preloaded with ROM[i] = 16'hA000 + i. A per-instance
//   monitor logs accepts and response handshakes with their clock-edge index.
module tb_instr_mem_stream;

  localparam logic [15:0] FILL = 16'hDEAD;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [15:0] req_addr;
  logic        flush;
  logic        rsp_ready;
  int          cyc;
  int          checks;
  int          errors;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic        err;
    int          cyc;
  } rsp_t;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] exp_instr;
    logic        exp_err;
  } vec_t;

  rsp_t q1[$];
  rsp_t q2[$];
  int   acc1_q[$];
  int   acc2_q[$];
  vec_t vecs[8];

  instr_mem_stream_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus1();
  instr_mem_stream_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus2();

  assign bus1.req_valid = req_valid;
  assign bus1.req_addr  = req_addr;
  assign bus1.flush     = flush;
  assign bus1.rsp_ready = rsp_ready;
  assign bus2.req_valid = req_valid;
  assign bus2.req_addr  = req_addr;
  assign bus2.flush     = flush;
  assign bus2.rsp_ready = rsp_ready;

  instr_mem_stream #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .READ_LATENCY(1),
                     .RSP_DEPTH(4), .FILL_WORD(FILL)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  instr_mem_stream #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .DEPTH(256), .READ_LATENCY(2),
                     .RSP_DEPTH(4), .FILL_WORD(FILL)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  // A handshake seen at this negedge completes on edge cyc+1.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.rsp_valid && bus1.rsp_ready) q1.push_back('{bus1.rsp_addr, bus1.rsp_instr, bus1.rsp_err, cyc});
      if (bus2.rsp_valid && bus2.rsp_ready) q2.push_back('{bus2.rsp_addr, bus2.rsp_instr, bus2.rsp_err, cyc});
      if (bus1.req_valid && bus1.req_ready) acc1_q.push_back(cyc + 1);
      if (bus2.req_valid && bus2.req_ready) acc2_q.push_back(cyc + 1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    q1.delete();
    q2.delete();
    acc1_q.delete();
    acc2_q.delete();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    flush     = 1'b0;
    rsp_ready = 1'b0;

    vecs[0] = '{16'h0000, 16'hA000, 1'b0};
    vecs[1] = '{16'h0001, 16'hA001, 1'b0};
    vecs[2] = '{16'h0007, 16'hA007, 1'b0};
    vecs[3] = '{16'h0028, 16'hA028, 1'b0};
    vecs[4] = '{16'h00FF, 16'hA0FF, 1'b0};
`ifdef IMEM_BOUNDS_CHECK_EN
    vecs[5] = '{16'h0105, FILL, 1'b1};
    vecs[6] = '{16'h0100, FILL, 1'b1};
    vecs[7] = '{16'hFFFF, FILL, 1'b1};
`else
    vecs[5] = '{16'h0105, 16'hA005, 1'b0};
    vecs[6] = '{16'h0100, 16'hA000, 1'b0};
    vecs[7] = '{16'hFFFF, 16'hA0FF, 1'b0};
`endif

    for (int i = 0; i < 256; i++) begin
      dut1.rom[i] = 16'hA000 + 16'(i);
      dut2.rom[i] = 16'hA000 + 16'(i);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(bus1.req_ready), 0);
    check("rst_rsp_valid", 32'(bus1.rsp_valid), 0);
    check("rst_rsp_instr", 32'(bus1.rsp_instr), 0);
    check("rst_rsp_addr", 32'(bus1.rsp_addr), 0);
    check("rst_rsp_err", 32'(bus1.rsp_err), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_before_clk", 32'(bus1.req_ready), 0);
    step();
    @(negedge clk);
    check("rel_ready_after_clk", 32'(bus1.req_ready), 1);
    check("rel_ready_after_clk_l2", 32'(bus2.req_ready), 1);

    // Single-request vectors, including out-of-range addresses
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      step();
      clear_logs();
      req_valid = 1'b1;
      req_addr  = vecs[v].addr;
      step();
      req_valid = 1'b0;
      repeat (5) step();
      check($sformatf("vec%0d_count_l1", v), 32'(q1.size()), 1);
      check($sformatf("vec%0d_count_l2", v), 32'(q2.size()), 1);
      if (q1.size() > 0) begin
        check($sformatf("vec%0d_instr_l1", v), 32'(q1[0].instr), 32'(vecs[v].exp_instr));
        check($sformatf("vec%0d_err_l1", v), 32'(q1[0].err), 32'(vecs[v].exp_err));
        check($sformatf("vec%0d_addr_l1", v), 32'(q1[0].addr), 32'(vecs[v].addr));
      end
      if (q2.size() > 0) begin
        check($sformatf("vec%0d_instr_l2", v), 32'(q2[0].instr), 32'(vecs[v].exp_instr));
        check($sformatf("vec%0d_err_l2", v), 32'(q2[0].err), 32'(vecs[v].exp_err));
      end
    end

    // Stream: addr 0..7 back-to-back, one response per cycle at fixed latency
    clear_logs();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_addr = 16'(k);
      step();
    end
    req_valid = 1'b0;
    repeat (8) step();
    check("stream_accepts_l1", 32'(acc1_q.size()), 8);
    check("stream_accepts_l2", 32'(acc2_q.size()), 8);
    check("stream_rsps_l1", 32'(q1.size()), 8);
    check("stream_rsps_l2", 32'(q2.size()), 8);
    if (q1.size() == 8 && q2.size() == 8 && acc1_q.size() == 8 && acc2_q.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        check($sformatf("stream%0d_addr_l1", k), 32'(q1[k].addr), 32'(k));
        check($sformatf("stream%0d_instr_l1", k), 32'(q1[k].instr), 32'(16'hA000 + 16'(k)));
        check($sformatf("stream%0d_cyc_l1", k), 32'(q1[k].cyc), 32'(acc1_q[0] + 1 + k));
        check($sformatf("stream%0d_addr_l2", k), 32'(q2[k].addr), 32'(k));
        check($sformatf("stream%0d_instr_l2", k), 32'(q2[k].instr), 32'(16'hA000 + 16'(k)));
        check($sformatf("stream%0d_cyc_l2", k), 32'(q2[k].cyc), 32'(acc2_q[0] + 2 + k));
      end
    end

    // Backpressure: exactly RSP_DEPTH accepts, head held stable, then drain
    clear_logs();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 16'h0000;
    for (int k = 0; k < 8; k++) begin
      step();
      req_addr = 16'(acc1_q.size());
    end
    @(negedge clk);
    check("bp_accepts_l1", 32'(acc1_q.size()), 4);
    check("bp_accepts_l2", 32'(acc2_q.size()), 4);
    check("bp_ready_low_l1", 32'(bus1.req_ready), 0);
    check("bp_ready_low_l2", 32'(bus2.req_ready), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_hold_valid_l1", 32'(bus1.rsp_valid), 1);
      check("bp_hold_instr_l1", 32'(bus1.rsp_instr), 32'h0000A000);
      check("bp_hold_instr_l2", 32'(bus2.rsp_instr), 32'h0000A000);
      check("bp_hold_addr_l1", 32'(bus1.rsp_addr), 0);
    end
    step();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) step();
    check("bp_drain_l1", 32'(q1.size()), 4);
    check("bp_drain_l2", 32'(q2.size()), 4);
    if (q1.size() == 4 && q2.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("bp%0d_instr_l1", k), 32'(q1[k].instr), 32'(16'hA000 + 16'(k)));
        check($sformatf("bp%0d_instr_l2", k), 32'(q2[k].instr), 32'(16'hA000 + 16'(k)));
      end
    end

    // Flush: 10..12 in flight and buffered, then discarded
    clear_logs();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    for (int k = 10; k <= 12; k++) begin
      req_addr = 16'(k);
      step();
    end
    flush    = 1'b1;
    req_addr = 16'd99;
    @(negedge clk);
    check("flush_ready_low_l1", 32'(bus1.req_ready), 0);
    check("flush_ready_low_l2", 32'(bus2.req_ready), 0);
    step();
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_valid_l1", 32'(bus1.rsp_valid), 0);
    check("flush_valid_l2", 32'(bus2.rsp_valid), 0);
    check("flush_ready_back_l1", 32'(bus1.req_ready), 1);
    step();
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = 16'd40;
    step();
    req_valid = 1'b0;
    repeat (6) step();
    check("flush_accepts_l1", 32'(acc1_q.size()), 4);
    check("flush_rsps_l1", 32'(q1.size()), 1);
    check("flush_rsps_l2", 32'(q2.size()), 1);
    if (q1.size() > 0) begin
      check("flush_addr_l1", 32'(q1[0].addr), 40);
      check("flush_instr_l1", 32'(q1[0].instr), 32'h0000A028);
    end
    if (q2.size() > 0) begin
      check("flush_addr_l2", 32'(q2[0].addr), 40);
      check("flush_instr_l2", 32'(q2[0].instr), 32'h0000A028);
    end

    // Async reset mid-burst with two buffered responses
    clear_logs();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr  = 16'd20;
    step();
    req_addr  = 16'd21;
    step();
    req_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    check("areset_pre_valid_l1", 32'(bus1.rsp_valid), 1);
    check("areset_pre_valid_l2", 32'(bus2.rsp_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid_l1", 32'(bus1.rsp_valid), 0);
    check("areset_valid_l2", 32'(bus2.rsp_valid), 0);
    check("areset_ready", 32'(bus1.req_ready), 0);
    repeat (2) step();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    repeat (5) step();
    check("areset_no_rsp_l1", 32'(q1.size()), 0);
    check("areset_no_rsp_l2", 32'(q2.size()), 0);
    req_valid = 1'b1;
    req_addr  = 16'd50;
    step();
    req_valid = 1'b0;
    repeat (6) step();
    check("areset_new_rsp_l1", 32'(q1.size()), 1);
    if (q1.size() > 0) begin
      check("areset_new_addr_l1", 32'(q1[0].addr), 50);
      check("areset_new_instr_l1", 32'(q1[0].instr), 32'h0000A032);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
